// File: rtl/pipe_pkg.sv
// Shared pipeline constants and typedefs for the ID-stage register file and its
// pending-write scoreboard.
package pipe_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NREGS      = 32;
    localparam int CNT_W      = 2;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [CNT_W-1:0]      sb_cnt_t;

    localparam sb_cnt_t SB_CNT_MAX  = {CNT_W{1'b1}};
    localparam sb_cnt_t SB_CNT_ZERO = {CNT_W{1'b0}};
    localparam sb_cnt_t SB_CNT_ONE  = sb_cnt_t'(1);

endpackage

// File: rtl/wb_regfile_scoreboard_sb_counter.sv
// Per-register pending-write counter: one increment and up to two decrements per
// cycle, clamped to [0, max], plus its underflow checker.
module sb_counter
    import pipe_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_inc,
    input  logic [1:0] i_dec,
    output sb_cnt_t    o_count
);

    sb_cnt_t          count_d;
    sb_cnt_t          count_q;
    logic [CNT_W:0]   sum_s;
    logic [CNT_W:0]   net_s;
    logic             underflow_s;

    // Net the increment against the decrements one bit wider so both ends clamp cleanly
    always_comb begin
        sum_s       = {1'b0, count_q} + {{CNT_W{1'b0}}, i_inc};
        underflow_s = (sum_s < {{(CNT_W-1){1'b0}}, i_dec});
        net_s       = {(CNT_W+1){1'b0}};
        count_d     = count_q;
        if (underflow_s) begin
            net_s = {(CNT_W+1){1'b0}};
        end else begin
            net_s = sum_s - {{(CNT_W-1){1'b0}}, i_dec};
        end
        if (net_s > {1'b0, SB_CNT_MAX}) begin
            count_d = SB_CNT_MAX;
        end else begin
            count_d = net_s[CNT_W-1:0];
        end
    end

    // Counter state register
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            count_q <= SB_CNT_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

    sb_counter_chk u_chk (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_underflow (underflow_s)
    );

endmodule

// A commit or squash against a register with nothing pending is a pipeline bug.
module sb_counter_chk (
    input logic i_clk,
    input logic i_reset,
    input logic i_underflow
);

    a_no_underflow: assert property (@(posedge i_clk) disable iff (!i_reset) !i_underflow)
        else $error("sb_counter: pending-write count underflow");

endmodule

// File: rtl/wb_regfile_scoreboard.sv
// ID-stage integer register file with write-first WB bypass and a pending-write
// scoreboard for RAW stalls. Optional macro REGFILE_DEBUG_PORT_EN adds debug ports.
module wb_regfile_scoreboard
    import pipe_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  reg_addr_t        i_rs1_addr,
    input  reg_addr_t        i_rs2_addr,
    output logic [XLEN-1:0]  o_rs1_data,
    output logic [XLEN-1:0]  o_rs2_data,
    output logic             o_rs1_busy,
    output logic             o_rs2_busy,
    input  logic             i_issue_valid,
    input  reg_addr_t        i_issue_rd_addr,
    input  logic             i_squash_valid,
    input  reg_addr_t        i_squash_rd_addr,
    input  logic             i_wb_rd_wren,
    input  reg_addr_t        i_wb_rd_addr,
    input  logic [XLEN-1:0]  i_wb_rd_data,
`ifdef REGFILE_DEBUG_PORT_EN
    input  reg_addr_t        i_dbg_addr,
    output logic [XLEN-1:0]  o_dbg_data,
    output logic [NREGS-1:0] o_busy_vec,
`endif
    output logic             o_stall
);

    logic [XLEN-1:0]                regs_d [NREGS];
    logic [XLEN-1:0]                regs_q [NREGS];
    logic [NREGS-1:1]               inc_s;
    logic [NREGS-1:1][1:0]          dec_s;
    logic [NREGS-1:0][CNT_W-1:0]    cnt_s;
    sb_cnt_t                        rs1_cnt_s;
    sb_cnt_t                        rs2_cnt_s;
    logic                           wb_hit_rs1_s;
    logic                           wb_hit_rs2_s;

    // Next storage contents: x0 is never written
    always_comb begin
        regs_d = regs_q;
        if (i_wb_rd_wren && (i_wb_rd_addr != reg_addr_t'(0))) begin
            regs_d[i_wb_rd_addr] = i_wb_rd_data;
        end else begin
            regs_d = regs_q;
        end
    end

    // Register storage
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Per-register issue/commit/squash events feeding the scoreboard
    always_comb begin
        inc_s = '0;
        dec_s = '0;
        for (int r = 1; r < NREGS; r++) begin
            inc_s[r] = i_issue_valid && (i_issue_rd_addr == reg_addr_t'(r));
            dec_s[r] = {1'b0, (i_wb_rd_wren && (i_wb_rd_addr == reg_addr_t'(r)))}
                     + {1'b0, (i_squash_valid && (i_squash_rd_addr == reg_addr_t'(r)))};
        end
    end

    assign cnt_s[0] = SB_CNT_ZERO;

    for (genvar g = 1; g < NREGS; g++) begin : g_sb
        sb_counter u_cnt (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_inc   (inc_s[g]),
            .i_dec   (dec_s[g]),
            .o_count (cnt_s[g])
        );
    end

    // Bypassed reads, busy flags and stall; a last pending write committing now is not busy
    always_comb begin
        wb_hit_rs1_s = i_wb_rd_wren && (i_wb_rd_addr == i_rs1_addr);
        wb_hit_rs2_s = i_wb_rd_wren && (i_wb_rd_addr == i_rs2_addr);
        rs1_cnt_s    = cnt_s[i_rs1_addr];
        rs2_cnt_s    = cnt_s[i_rs2_addr];
        if (wb_hit_rs1_s && (i_rs1_addr != reg_addr_t'(0))) begin
            o_rs1_data = i_wb_rd_data;
        end else begin
            o_rs1_data = regs_q[i_rs1_addr];
        end
        if (wb_hit_rs2_s && (i_rs2_addr != reg_addr_t'(0))) begin
            o_rs2_data = i_wb_rd_data;
        end else begin
            o_rs2_data = regs_q[i_rs2_addr];
        end
        o_rs1_busy = (rs1_cnt_s != SB_CNT_ZERO) && !(wb_hit_rs1_s && (rs1_cnt_s == SB_CNT_ONE));
        o_rs2_busy = (rs2_cnt_s != SB_CNT_ZERO) && !(wb_hit_rs2_s && (rs2_cnt_s == SB_CNT_ONE));
        o_stall    = o_rs1_busy || o_rs2_busy
                  || (i_issue_valid && (cnt_s[i_issue_rd_addr] == SB_CNT_MAX));
    end

`ifdef REGFILE_DEBUG_PORT_EN
    // Raw storage view and scoreboard occupancy for debug
    always_comb begin
        o_dbg_data = regs_q[i_dbg_addr];
        o_busy_vec = '0;
        for (int r = 1; r < NREGS; r++) begin
            o_busy_vec[r] = (cnt_s[r] != SB_CNT_ZERO);
        end
    end
`endif

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Randomized bench for wb_regfile_scoreboard against a queue-free array model of
// the architectural registers and their outstanding-write counts.
module tb_wb_regfile_scoreboard;

    logic        i_clk;
    logic        i_reset;
    logic [4:0]  rs1, rs2, issue_rd, squash_rd, wb_rd;
    logic        issue_v, squash_v, wb_en;
    logic [31:0] wb_data;
    logic [31:0] o_rs1_data, o_rs2_data;
    logic        o_rs1_busy, o_rs2_busy, o_stall;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mdl_reg [32];
    int          mdl_cnt [32];
    logic        exp_stall_last;

    wb_regfile_scoreboard dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_rs1_addr       (rs1),
        .i_rs2_addr       (rs2),
        .o_rs1_data       (o_rs1_data),
        .o_rs2_data       (o_rs2_data),
        .o_rs1_busy       (o_rs1_busy),
        .o_rs2_busy       (o_rs2_busy),
        .i_issue_valid    (issue_v),
        .i_issue_rd_addr  (issue_rd),
        .i_squash_valid   (squash_v),
        .i_squash_rd_addr (squash_rd),
        .i_wb_rd_wren     (wb_en),
        .i_wb_rd_addr     (wb_rd),
        .i_wb_rd_data     (wb_data),
        .o_stall          (o_stall)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tb_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_en && wb_rd == a) return wb_data;
        return mdl_reg[a];
    endfunction

    // Busy means writes are still outstanding once this cycle's commit is counted.
    function automatic logic exp_busy(input logic [4:0] a);
        int left;
        left = mdl_cnt[a] - ((wb_en && wb_rd == a) ? 1 : 0);
        return (a != 5'd0) && (left > 0);
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            mdl_reg[r] = 32'd0;
            mdl_cnt[r] = 0;
        end
        exp_stall_last = 1'b0;
    endtask

    task automatic drive(input logic iv, input logic [4:0] ird, input logic sv, input logic [4:0] srd,
                         input logic we, input logic [4:0] wrd, input logic [31:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2);
        issue_v = iv; issue_rd = ird; squash_v = sv; squash_rd = srd;
        wb_en = we; wb_rd = wrd; wb_data = wd; rs1 = a1; rs2 = a2;
    endtask

    // Check all outputs against the model, clock once, then advance the model.
    task automatic step();
        logic b1, b2, st;
        int   n;
        #1;
        b1 = exp_busy(rs1);
        b2 = exp_busy(rs2);
        st = b1 || b2 || (issue_v && issue_rd != 5'd0 && mdl_cnt[issue_rd] == 3);
        tb_check("rs1_data", o_rs1_data, exp_data(rs1));
        tb_check("rs2_data", o_rs2_data, exp_data(rs2));
        tb_check("rs1_busy", {31'd0, o_rs1_busy}, {31'd0, b1});
        tb_check("rs2_busy", {31'd0, o_rs2_busy}, {31'd0, b2});
        tb_check("stall", {31'd0, o_stall}, {31'd0, st});
        exp_stall_last = st;
        @(posedge i_clk);
        if (wb_en && wb_rd != 5'd0) mdl_reg[wb_rd] = wb_data;
        for (int r = 1; r < 32; r++) begin
            n = mdl_cnt[r] + ((issue_v && issue_rd == r) ? 1 : 0)
                           - ((wb_en && wb_rd == r) ? 1 : 0)
                           - ((squash_v && squash_rd == r) ? 1 : 0);
            mdl_cnt[r] = (n < 0) ? 0 : ((n > 3) ? 3 : n);
        end
        @(negedge i_clk);
    endtask

    task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, a1, a2);
    endtask

    initial begin
        logic       iv, sv, we;
        logic [4:0] ird, srd, wrd;
        int         avail;

        model_clear();
        i_reset = 1'b0;
        idle(5'd5, 5'd0);
        #3;
        tb_check("reset_rs1_x5", o_rs1_data, 32'd0);
        tb_check("reset_busy", {31'd0, o_rs1_busy}, 32'd0);
        tb_check("reset_stall", {31'd0, o_stall}, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b1;

        drive(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0); step();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd0); step();
        idle(5'd5, 5'd0); #1;
        tb_check("x5_after_wb", o_rs1_data, 32'hDEADBEEF);
        tb_check("x5_not_busy", {31'd0, o_rs1_busy}, 32'd0);
        step();

        drive(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0); step();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h0000_1234, 5'd7, 5'd0); #1;
        tb_check("x7_bypass", o_rs1_data, 32'h0000_1234);
        step();

        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0); #1;
        tb_check("x0_bypass_blocked", o_rs1_data, 32'd0);
        step();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0); step();
        idle(5'd0, 5'd0); #1;
        tb_check("x0_reads_zero", o_rs1_data, 32'd0);
        tb_check("x0_no_stall", {31'd0, o_stall}, 32'd0);
        step();

        drive(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0); step();
        idle(5'd0, 5'd3); #1;
        tb_check("raw_busy", {31'd0, o_rs2_busy}, 32'd1);
        tb_check("raw_stall", {31'd0, o_stall}, 32'd1);
        step();
        idle(5'd0, 5'd3); step();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 32'hCAFE_0003, 5'd0, 5'd3); #1;
        tb_check("raw_wb_unbusy", {31'd0, o_rs2_busy}, 32'd0);
        tb_check("raw_wb_bypass", o_rs2_data, 32'hCAFE_0003);
        step();

        drive(1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0); step();
        drive(1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd0); step();
        drive(1'b0, 5'd0, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0, 5'd4, 5'd0); step();
        idle(5'd4, 5'd0); #1;
        tb_check("x4_busy_cnt1", {31'd0, o_rs1_busy}, 32'd1);
        step();
        drive(1'b1, 5'd4, 1'b0, 5'd0, 1'b1, 5'd4, 32'h4444_0001, 5'd0, 5'd0); step();
        idle(5'd4, 5'd0); #1;
        tb_check("x4_issue_wb_same", {31'd0, o_rs1_busy}, 32'd1);
        step();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 32'h4444_0002, 5'd4, 5'd0); step();
        idle(5'd4, 5'd0); #1;
        tb_check("x4_cleared", {31'd0, o_rs1_busy}, 32'd0);
        step();

        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0); step();
        end
        drive(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0); #1;
        tb_check("sat_stall", {31'd0, o_stall}, 32'd1);
        step();
        idle(5'd9, 5'd0); #2;
        i_reset = 1'b0;
        drive(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd4);
        #1;
        tb_check("rst_mid_stall", {31'd0, o_stall}, 32'd0);
        tb_check("rst_mid_busy", {31'd0, o_rs1_busy}, 32'd0);
        tb_check("rst_mid_data", o_rs2_data, 32'd0);
        model_clear();
        idle(5'd0, 5'd0);
        @(negedge i_clk);
        i_reset = 1'b1;

        for (int c = 0; c < 400; c++) begin
            iv  = (!exp_stall_last) && ($urandom_range(0, 2) != 0);
            ird = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            wrd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            avail = mdl_cnt[wrd] + ((iv && ird == wrd) ? 1 : 0);
            we  = ($urandom_range(0, 1) == 1) && (wrd == 5'd0 || avail > 0);
            srd = 5'($urandom_range(0, 7));
            avail = mdl_cnt[srd] + ((iv && ird == srd) ? 1 : 0) - ((we && wrd == srd) ? 1 : 0);
            sv  = ($urandom_range(0, 4) == 0) && (srd != 5'd0) && (avail > 0);
            drive(iv, ird, sv, srd, we, wrd, $urandom,
                  5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
